// File: rtl/video_timing_pipe.sv
// rtl/video_timing_pipe.sv - video timing generator with lead-compensated pixel capture and RGB expansion
// Define VIDEO_TEST_PATTERN_EN to add the tp_en port and the colour-bar generator.
module video_timing_pipe #(
  parameter int H_ACTIVE = 1920,
  parameter int H_FP     = 88,
  parameter int H_SYNC   = 44,
  parameter int H_BP     = 148,
  parameter int V_ACTIVE = 1080,
  parameter int V_FP     = 4,
  parameter int V_SYNC   = 5,
  parameter int V_BP     = 36,
  parameter int HS_POL   = 1,
  parameter int VS_POL   = 1,
  parameter int REQ_LEAD = 1,
  parameter int PIPE_DLY = 0,
  parameter int IN_FMT   = 0,
  parameter int XY_W     = 11
) (
  input  logic            pixel_clk,
  input  logic            sys_rst_n,
  input  logic            en,
`ifdef VIDEO_TEST_PATTERN_EN
  input  logic            tp_en,
`endif
  input  logic [23:0]     data_in,
  output logic            data_req,
  output logic [XY_W-1:0] pixel_xpos,
  output logic [XY_W-1:0] pixel_ypos,
  output logic            frame_start,
  output logic            video_hs,
  output logic            video_vs,
  output logic            video_de,
  output logic [23:0]     video_rgb
);

  localparam int H_TOTAL = H_SYNC + H_BP + H_ACTIVE + H_FP;
  localparam int V_TOTAL = V_SYNC + V_BP + V_ACTIVE + V_FP;
  localparam int HW = $clog2(H_TOTAL);
  localparam int VW = $clog2(V_TOTAL);

  localparam logic [HW-1:0] H_LAST = HW'(H_TOTAL - 1);
  localparam logic [HW-1:0] H_S1   = HW'(H_SYNC);
  localparam logic [HW-1:0] H_A0   = HW'(H_SYNC + H_BP);
  localparam logic [HW-1:0] H_A1   = HW'(H_SYNC + H_BP + H_ACTIVE);
  localparam logic [VW-1:0] V_LAST = VW'(V_TOTAL - 1);
  localparam logic [VW-1:0] V_S1   = VW'(V_SYNC);
  localparam logic [VW-1:0] V_A0   = VW'(V_SYNC + V_BP);
  localparam logic [VW-1:0] V_A1   = VW'(V_SYNC + V_BP + V_ACTIVE);
  localparam logic HS_ON = (HS_POL != 0);
  localparam logic VS_ON = (VS_POL != 0);

  // Lead-chain word: {hs, vs, de} plus, with the pattern, {tp, bar[2:0]}
`ifdef VIDEO_TEST_PATTERN_EN
  localparam int LW = 7;
  localparam int TP_B = 3;
`else
  localparam int LW = 3;
`endif
  localparam int HS_B = LW - 1;
  localparam int VS_B = LW - 2;
  localparam int DE_B = LW - 3;

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN} state_t;

  state_t            r_state;
  state_t            w_state_nxt;
  logic [HW-1:0]     r_h;
  logic [VW-1:0]     r_v;
  logic              r_req;
  logic [XY_W-1:0]   r_x;
  logic [XY_W-1:0]   r_y;
  logic              r_fs;
  logic [LW-1:0]     r_lead [0:REQ_LEAD];
  logic [26:0]       r_pipe [0:PIPE_DLY];

  logic              w_run;
  logic              w_last;
  logic              w_fs;
  logic              w_hs;
  logic              w_vs;
  logic              w_act;
  logic              w_tp;
  logic              w_req;
  logic [XY_W-1:0]   w_x;
  logic [XY_W-1:0]   w_y;
  logic [LW-1:0]     w_lead_in;
  logic [LW-1:0]     w_lead_out;
  logic [23:0]       w_conv;
  logic [23:0]       w_rgb;

  assign w_run  = (r_state != S_IDLE);
  assign w_last = (r_h == H_LAST) && (r_v == V_LAST);
  assign w_fs   = (r_state == S_RUN) && (r_h == '0) && (r_v == '0);
  assign w_hs   = w_run && (r_h < H_S1);
  assign w_vs   = w_run && (r_v < V_S1);
  assign w_act  = w_run && (r_h >= H_A0) && (r_h < H_A1) && (r_v >= V_A0) && (r_v < V_A1);
  assign w_x    = XY_W'(r_h - H_A0);
  assign w_y    = XY_W'(r_v - V_A0);
  assign w_req  = w_act && !w_tp;

  always_ff @(posedge pixel_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) r_state <= S_IDLE;
    else            r_state <= w_state_nxt;
  end

  // A frame is always finished before returning to IDLE
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (en) w_state_nxt = S_RUN;
      S_RUN:   if (!en) w_state_nxt = w_last ? S_IDLE : S_DRAIN;
      S_DRAIN: begin
        if (en)          w_state_nxt = S_RUN;
        else if (w_last) w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge pixel_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      r_h <= '0;
      r_v <= '0;
    end else if (r_state == S_IDLE) begin
      r_h <= '0;
      r_v <= '0;
    end else if (r_h == H_LAST) begin
      r_h <= '0;
      r_v <= (r_v == V_LAST) ? '0 : r_v + VW'(1);
    end else begin
      r_h <= r_h + HW'(1);
    end
  end

`ifdef VIDEO_TEST_PATTERN_EN
  logic       r_tp;
  logic [2:0] w_bar;

  always_ff @(posedge pixel_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) r_tp <= 1'b0;
    else if (w_fs)  r_tp <= tp_en;
  end

  assign w_tp      = r_tp;
  assign w_bar     = 3'((32'(w_x) * 8) / H_ACTIVE);
  assign w_lead_in = {w_hs, w_vs, w_act, r_tp, w_bar};
`else
  assign w_tp      = 1'b0;
  assign w_lead_in = {w_hs, w_vs, w_act};
`endif

  assign w_lead_out = r_lead[REQ_LEAD];

  always_comb begin
    w_conv = '0;
    case (IN_FMT)
      0:       w_conv = {data_in[15:11], data_in[15:13], data_in[10:5], data_in[10:9],
                         data_in[4:0], data_in[4:2]};
      1:       w_conv = data_in;
      default: w_conv = {3{data_in[15:8]}};
    endcase
    w_rgb = '0;
    if (w_lead_out[DE_B]) w_rgb = w_conv;
`ifdef VIDEO_TEST_PATTERN_EN
    // Bar order white..black maps to R=~b[1], G=~b[2], B=~b[0]
    if (w_lead_out[DE_B] && w_lead_out[TP_B])
      w_rgb = {{8{~w_lead_out[1]}}, {8{~w_lead_out[2]}}, {8{~w_lead_out[0]}}};
`endif
  end

  always_ff @(posedge pixel_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      r_req <= 1'b0;
      r_x   <= '0;
      r_y   <= '0;
      r_fs  <= 1'b0;
      for (int i = 0; i <= REQ_LEAD; i++) r_lead[i] <= '0;
      for (int i = 0; i <= PIPE_DLY; i++) r_pipe[i] <= '0;
    end else begin
      r_req     <= w_req;
      r_x       <= w_req ? w_x : '0;
      r_y       <= w_req ? w_y : '0;
      r_fs      <= w_fs;
      r_lead[0] <= w_lead_in;
      for (int i = 1; i <= REQ_LEAD; i++) r_lead[i] <= r_lead[i-1];
      r_pipe[0] <= {w_lead_out[HS_B], w_lead_out[VS_B], w_lead_out[DE_B], w_rgb};
      for (int i = 1; i <= PIPE_DLY; i++) r_pipe[i] <= r_pipe[i-1];
    end
  end

  assign data_req    = r_req;
  assign pixel_xpos  = r_x;
  assign pixel_ypos  = r_y;
  assign frame_start = r_fs;
  assign video_hs    = r_pipe[PIPE_DLY][26] ? HS_ON : ~HS_ON;
  assign video_vs    = r_pipe[PIPE_DLY][25] ? VS_ON : ~VS_ON;
  assign video_de    = r_pipe[PIPE_DLY][24];
  assign video_rgb   = r_pipe[PIPE_DLY][23:0];

endmodule
